cpu_run_monitor: RTL
====================

// Module: cpu_run_monitor
// PURPOSE
//  Parametrised run controller/monitor for pipelined CPU simulation and bring-up. Counts cycles and
//  retired PCs while run_en is high. Terminates the run on end-PC hit, PC stall (halt loop) or
//  cycle timeout, and reports which one fired. Keeps a circular trace of recent PCs. Sits beside
//  xgriscv_pipeline, fed by its pc output; replaces fixed-count stop logic in benches.
// PARAMETERS
//  PC_W        32            width of pc and trace entries
//  CNT_W       32            width of cycle/instr counters (saturating)
//  MAX_CYCLES  500           timeout in counted cycles; 0 = timeout disabled
//  USE_END_PC  1             1 = end-PC detection enabled
//  END_PC      32'h0000_0000 terminating PC value
//  STALL_LIMIT 16            consecutive repeated-PC samples that mean halt; 0 = disabled
//  TRACE_DEPTH 8             trace entries, power of 2, >=2
// PORTS
//  clk        in  1                   clock, rising edge
//  reset      in  1                   asynchronous, active-low reset
//  clear      in  1                   synchronous restart to IDLE
//  run_en     in  1                   start/continue counting; low = pause
//  pc_valid   in  1                   pc is a valid sample this cycle
//  pc         in  PC_W                current CPU PC
//  trace_idx  in  $clog2(TRACE_DEPTH) trace read index, 0 = most recent
//  trace_pc   out PC_W                trace entry at trace_idx (combinational read)
//  trace_cnt  out $clog2(TRACE_DEPTH)+1  valid trace entries
//  cycle_cnt  out CNT_W               counted cycles
//  instr_cnt  out CNT_W               counted valid pc samples
//  running    out 1                   state==RUN
//  done       out 1                   state==DONE (sticky)
//  status     out 2                   00 none, 01 end-PC, 10 stall, 11 timeout
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, all counters/trace_cnt/status=0, done=running=0, last_pc_vld=0.
//  clear==1 at edge: same as reset, synchronous, overrides every other event; trace contents
//  need not be zeroed (trace_cnt=0 hides them).
//  FSM IDLE->RUN on edge with run_en==1; that edge counts as RUN cycle 1.
//  FSM RUN->DONE on terminating edge. DONE holds until clear/reset; run_en/pc ignored in DONE.
//  Counted edge: state in {IDLE-entering, RUN} and run_en==1. Per counted edge:
//   - cycle_cnt+=1 (saturate at all-ones).
//   - If pc_valid: instr_cnt+=1, push pc to trace, update last_pc, set last_pc_vld.
//  Stall count, pc_valid only:
//   - if last_pc_vld && pc==last_pc: stall_cnt+=1; else stall_cnt=0.
//   - stall_cnt saturates at STALL_LIMIT.
//   - pc_valid==0 holds stall_cnt.
//  run_en==0 in RUN: pause, all counters/trace hold, state stays RUN.
//  Termination is evaluated on the updated values of the same counted edge.
//   - end: USE_END_PC && pc_valid && pc==END_PC.
//   - stall: STALL_LIMIT!=0 && new stall_cnt==STALL_LIMIT.
//   - timeout: MAX_CYCLES!=0 && new cycle_cnt==MAX_CYCLES.
//   - Priority on simultaneous hit: end > stall > timeout. The edge that terminates still does
//     its counting and trace push. done/status are registered: visible after that edge.
//  Trace: circular buffer with write pointer.
//   - trace_cnt saturates at TRACE_DEPTH; on overflow the oldest entry is overwritten.
//   - trace_pc = entry (wptr-1-trace_idx) mod DEPTH; 0 when trace_idx>=trace_cnt.
//  No X on outputs after reset; pc compared only when pc_valid==1.
// TESTING
//  1. Timeout: MAX_CYCLES=500, pc +4 each cycle from 0, run_en=1 -> done after edge 500,
//     cycle_cnt=500, instr_cnt=500, status=11.
//  2. End-PC: END_PC=0x40, pc 0,4,..,0x40 -> done after 17th sample, instr_cnt=17, status=01,
//     trace_pc[0]=0x40, trace_pc[1]=0x3C.
//  3. Stall: pc ramps to 0x1C, then held -> done 16 edges after the first repeat, status=10,
//     trace_cnt=8, all entries 0x1C.
//  4. Pause/valid gaps: run_en low for 10 cycles mid-run -> counters frozen; pc_valid low
//     cycles raise cycle_cnt only.
//  5. Wrap and priority: 12 pushes 0x0..0x2C -> trace_cnt=8, trace_pc[7]=0x10, trace_idx
//     beyond range reads 0. pc==END_PC on cycle MAX_CYCLES -> status=01.
//  6. Reset/clear mid-run at cycle 200 -> all outputs 0, IDLE. Re-run reproduces test 1.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Run controller/monitor for CPU bring-up: counts cycles and retired PCs, stops on
// end-PC, PC stall or timeout, and keeps a circular trace of recent PCs.
module cpu_run_monitor #(
  parameter int unsigned    PC_W        = 32,
  parameter int unsigned    CNT_W       = 32,
  parameter int unsigned    MAX_CYCLES  = 500,
  parameter int unsigned    USE_END_PC  = 1,
  parameter logic [PC_W-1:0] END_PC     = '0,
  parameter int unsigned    STALL_LIMIT = 16,
  parameter int unsigned    TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           run_en,
  input  logic                           pc_valid,
  input  logic [PC_W-1:0]                pc,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [PC_W-1:0]                trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               instr_cnt,
  output logic                           running,
  output logic                           done,
  output logic [1:0]                     status
);

  localparam int unsigned IDX_W  = $clog2(TRACE_DEPTH);
  localparam int unsigned TCNT_W = IDX_W + 1;
  localparam int unsigned STL_W  = $clog2(STALL_LIMIT + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cycle_d, instr_d;
  logic [STL_W-1:0]   stall_q, stall_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic               last_vld_q, last_vld_d;
  logic [IDX_W-1:0]   wptr_q, wptr_d;
  logic [TCNT_W-1:0]  tcnt_d;
  logic [1:0]         status_d;
  logic               push;
  logic               end_hit, stall_hit, time_hit;
  logic [IDX_W-1:0]   rd_ptr;
  logic [PC_W-1:0]    trace_mem [TRACE_DEPTH];

  // Next-state and counter update; termination looks at the freshly updated counts.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_cnt;
    instr_d    = instr_cnt;
    stall_d    = stall_q;
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    wptr_d     = wptr_q;
    tcnt_d     = trace_cnt;
    status_d   = status;
    push       = 1'b0;
    end_hit    = 1'b0;
    stall_hit  = 1'b0;
    time_hit   = 1'b0;
    if (state_q != S_DONE && run_en) begin
      state_d = S_RUN;
      if (cycle_cnt != '1) cycle_d = cycle_cnt + CNT_W'(1);
      if (pc_valid) begin
        push       = 1'b1;
        last_pc_d  = pc;
        last_vld_d = 1'b1;
        wptr_d     = wptr_q + IDX_W'(1);
        if (instr_cnt != '1) instr_d = instr_cnt + CNT_W'(1);
        if (trace_cnt != TCNT_W'(TRACE_DEPTH)) tcnt_d = trace_cnt + TCNT_W'(1);
        if (last_vld_q && pc == last_pc_q) begin
          if (stall_q != STL_W'(STALL_LIMIT)) stall_d = stall_q + STL_W'(1);
        end else begin
          stall_d = '0;
        end
        end_hit = (USE_END_PC != 0) && (pc == END_PC);
      end
      stall_hit = (STALL_LIMIT != 0) && (stall_d == STL_W'(STALL_LIMIT));
      time_hit  = (MAX_CYCLES != 0) && (cycle_d == CNT_W'(MAX_CYCLES));
      if (end_hit || stall_hit || time_hit) begin
        state_d = S_DONE;
        if (end_hit)        status_d = 2'b01;
        else if (stall_hit) status_d = 2'b10;
        else                status_d = 2'b11;
      end
    end
  end

  // State and counter registers; clear acts as a synchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      stall_q    <= '0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      wptr_q     <= '0;
      trace_cnt  <= '0;
      status     <= 2'b00;
      running    <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      stall_q    <= '0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      wptr_q     <= '0;
      trace_cnt  <= '0;
      status     <= 2'b00;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_cnt  <= cycle_d;
      instr_cnt  <= instr_d;
      stall_q    <= stall_d;
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
      wptr_q     <= wptr_d;
      trace_cnt  <= tcnt_d;
      status     <= status_d;
      running    <= (state_d == S_RUN);
      done       <= (state_d == S_DONE);
    end
  end

  // Trace storage needs no reset: trace_cnt masks stale entries.
  always_ff @(posedge clk) begin
    if (push && reset && !clear) trace_mem[wptr_q] <= pc;
  end

  assign rd_ptr   = wptr_q - IDX_W'(1) - trace_idx;
  assign trace_pc = (TCNT_W'(trace_idx) < trace_cnt) ? trace_mem[rd_ptr] : '0;

endmodule
